ps2_ascii_decoder: RTL and testbench

//  Clocked, parametrised scancode-set-2 to ASCII decoder. Consumes raw PS/2 bytes, strips E0/F0/E1 prefixes,

---
 rtl/ps2_ascii_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// PS/2 scancode-set-2 to ASCII decoder: prefix FSM, modifier tracking, FWFT output FIFO.
// Optional PS2_DEC_REPEAT_FILTER_EN: drop typematic repeats of the last accepted make code.
module ps2_ascii_decoder #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter bit          CTRL_MAP   = 1'b1,
   parameter bit          ALT_MSB    = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    byte_in,
   input  logic                          byte_valid,
   output logic [7:0]                    ascii,
   output logic                          ascii_valid,
   input  logic                          ascii_ready,
   output logic                          shift_o,
   output logic                          caps_o,
   output logic                          ctrl_o,
   output logic                          alt_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic          lsh_q, lsh_d, rsh_q, rsh_d, lctl_q, lctl_d, rctl_q, rctl_d;
   logic          lalt_q, lalt_d, ralt_q, ralt_d, caps_q, caps_d, held_q, held_d;
   logic          shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [7:0]    head_q, head_d;
   logic          valid_q, valid_d, ovf_q, ovf_d;
`ifdef PS2_DEC_REPEAT_FILTER_EN
   logic          last_vld_q, last_vld_d;
   logic [8:0]    last_q, last_d;
`endif

   logic       ext_c, brk_c, ign_c, mod_c, final_c, push_c, pop_c, full_c, ok_c, drop_c, hi_c;
   logic       map_hit, map_letter;
   logic [7:0] map_lo, map_hi, ch_c;

   assign ext_c = (state_q == S_EXT) || (state_q == S_EXT_BRK);
   assign brk_c = (state_q == S_BRK) || (state_q == S_EXT_BRK);
   assign ign_c = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   assign mod_c = (!ext_c && (byte_in == 8'h12 || byte_in == 8'h59 || byte_in == 8'h58))
                  || byte_in == 8'h14 || byte_in == 8'h11;

   // US layout set-2 lookup: unshifted glyph in map_lo, shifted glyph in map_hi
   always_comb begin : map_table
      map_hit = 1'b1;
      map_lo  = 8'h00;
      map_hi  = 8'h00;
      if (ext_c) begin
         case (byte_in)
            8'h5A:   map_lo = 8'h0D;
            8'h4A:   map_lo = 8'h2F;
            default: map_hit = 1'b0;
         endcase
      end else begin
         case (byte_in)
            8'h1C: map_lo = 8'h61;  8'h32: map_lo = 8'h62;  8'h21: map_lo = 8'h63;
            8'h23: map_lo = 8'h64;  8'h24: map_lo = 8'h65;  8'h2B: map_lo = 8'h66;
            8'h34: map_lo = 8'h67;  8'h33: map_lo = 8'h68;  8'h43: map_lo = 8'h69;
            8'h3B: map_lo = 8'h6A;  8'h42: map_lo = 8'h6B;  8'h4B: map_lo = 8'h6C;
            8'h3A: map_lo = 8'h6D;  8'h31: map_lo = 8'h6E;  8'h44: map_lo = 8'h6F;
            8'h4D: map_lo = 8'h70;  8'h15: map_lo = 8'h71;  8'h2D: map_lo = 8'h72;
            8'h1B: map_lo = 8'h73;  8'h2C: map_lo = 8'h74;  8'h3C: map_lo = 8'h75;
            8'h2A: map_lo = 8'h76;  8'h1D: map_lo = 8'h77;  8'h22: map_lo = 8'h78;
            8'h35: map_lo = 8'h79;  8'h1A: map_lo = 8'h7A;
            8'h45: begin map_lo = 8'h30; map_hi = 8'h29; end
            8'h16: begin map_lo = 8'h31; map_hi = 8'h21; end
            8'h1E: begin map_lo = 8'h32; map_hi = 8'h40; end
            8'h26: begin map_lo = 8'h33; map_hi = 8'h23; end
            8'h25: begin map_lo = 8'h34; map_hi = 8'h24; end
            8'h2E: begin map_lo = 8'h35; map_hi = 8'h25; end
            8'h36: begin map_lo = 8'h36; map_hi = 8'h5E; end
            8'h3D: begin map_lo = 8'h37; map_hi = 8'h26; end
            8'h3E: begin map_lo = 8'h38; map_hi = 8'h2A; end
            8'h46: begin map_lo = 8'h39; map_hi = 8'h28; end
            8'h0E: begin map_lo = 8'h60; map_hi = 8'h7E; end
            8'h4E: begin map_lo = 8'h2D; map_hi = 8'h5F; end
            8'h55: begin map_lo = 8'h3D; map_hi = 8'h2B; end
            8'h5D: begin map_lo = 8'h5C; map_hi = 8'h7C; end
            8'h54: begin map_lo = 8'h5B; map_hi = 8'h7B; end
            8'h5B: begin map_lo = 8'h5D; map_hi = 8'h7D; end
            8'h4C: begin map_lo = 8'h3B; map_hi = 8'h3A; end
            8'h52: begin map_lo = 8'h27; map_hi = 8'h22; end
            8'h41: begin map_lo = 8'h2C; map_hi = 8'h3C; end
            8'h49: begin map_lo = 8'h2E; map_hi = 8'h3E; end
            8'h4A: begin map_lo = 8'h2F; map_hi = 8'h3F; end
            8'h29: map_lo = 8'h20;  8'h5A: map_lo = 8'h0D;  8'h66: map_lo = 8'h08;
            8'h0D: map_lo = 8'h09;  8'h76: map_lo = 8'h1B;
            default: map_hit = 1'b0;
         endcase
      end
      map_letter = !ext_c && (map_lo >= 8'h61) && (map_lo <= 8'h7A);
      if (map_letter)            map_hi = map_lo ^ 8'h20;
      else if (map_hi == 8'h00)  map_hi = map_lo;
   end

   // Prefix FSM, modifier update and character generation
   always_comb begin : next_state
      state_d = state_q;  skip_d = skip_q;
      lsh_d = lsh_q;  rsh_d = rsh_q;  lctl_d = lctl_q;  rctl_d = rctl_q;
      lalt_d = lalt_q;  ralt_d = ralt_q;  caps_d = caps_q;  held_d = held_q;
      final_c = 1'b0;  push_c = 1'b0;  drop_c = 1'b0;  hi_c = 1'b0;  ch_c = 8'h00;
`ifdef PS2_DEC_REPEAT_FILTER_EN
      last_vld_d = last_vld_q;  last_d = last_q;
`endif
      if (byte_valid) begin
         case (state_q)
            S_IDLE: begin
               if (byte_in == 8'hE0)      state_d = S_EXT;
               else if (byte_in == 8'hF0) state_d = S_BRK;
               else if (byte_in == 8'hE1) begin state_d = S_SKIP; skip_d = 3'd0; end
               else if (!ign_c)           final_c = 1'b1;
            end
            S_EXT: begin
               if (byte_in == 8'hF0)      state_d = S_EXT_BRK;
               else if (byte_in != 8'hE0) final_c = 1'b1;
            end
            S_BRK, S_EXT_BRK: if (byte_in != 8'hF0) final_c = 1'b1;
            S_SKIP: begin
               if (skip_q == 3'd6) state_d = S_IDLE;
               skip_d = skip_q + 3'd1;
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (final_c) begin
         state_d = S_IDLE;
         if (!ext_c && byte_in == 8'h12) lsh_d = !brk_c;
         if (!ext_c && byte_in == 8'h59) rsh_d = !brk_c;
         if (byte_in == 8'h14) begin if (ext_c) rctl_d = !brk_c; else lctl_d = !brk_c; end
         if (byte_in == 8'h11) begin if (ext_c) ralt_d = !brk_c; else lalt_d = !brk_c; end
         if (!ext_c && byte_in == 8'h58) begin
            if (!brk_c && !held_q) caps_d = !caps_q;
            held_d = !brk_c;
         end
`ifdef PS2_DEC_REPEAT_FILTER_EN
         if (brk_c) last_vld_d = 1'b0;
         else if (last_vld_q && last_q == {ext_c, byte_in}) drop_c = 1'b1;
         else begin last_vld_d = 1'b1; last_d = {ext_c, byte_in}; end
`endif
         hi_c = map_letter ? ((lsh_q | rsh_q) ^ caps_q) : (lsh_q | rsh_q);
         ch_c = hi_c ? map_hi : map_lo;
         if (CTRL_MAP && (lctl_q | rctl_q) && map_letter) ch_c = ch_c & 8'h1F;
         if (ALT_MSB && (lalt_q | ralt_q)) ch_c[7] = 1'b1;
         push_c = !brk_c && !mod_c && map_hit && !drop_c;
      end
      shift_d = lsh_d | rsh_d;
      ctrl_d  = lctl_d | rctl_d;
      alt_d   = lalt_d | ralt_d;
   end

   // FWFT FIFO; a push into a full FIFO succeeds only alongside a pop
   always_comb begin : fifo_next
      pop_c   = valid_q && ascii_ready;
      full_c  = (cnt_q == LW'(FIFO_DEPTH));
      ok_c    = push_c && (!full_c || pop_c);
      ovf_d   = push_c && full_c && !pop_c;
      mem_d   = mem_q;
      if (ok_c) mem_d[wr_q] = ch_c;
      wr_d    = ok_c  ? wr_q + AW'(1) : wr_q;
      rd_d    = pop_c ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q + LW'(ok_c) - LW'(pop_c);
      valid_d = (cnt_d != '0);
      head_d  = mem_d[rd_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;  skip_q <= '0;
         lsh_q <= 1'b0;  rsh_q <= 1'b0;  lctl_q <= 1'b0;  rctl_q <= 1'b0;
         lalt_q <= 1'b0;  ralt_q <= 1'b0;  caps_q <= 1'b0;  held_q <= 1'b0;
         shift_q <= 1'b0;  ctrl_q <= 1'b0;  alt_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q <= '0;  rd_q <= '0;  cnt_q <= '0;
         head_q <= '0;  valid_q <= 1'b0;  ovf_q <= 1'b0;
`ifdef PS2_DEC_REPEAT_FILTER_EN
         last_vld_q <= 1'b0;  last_q <= '0;
`endif
      end else begin
         state_q <= state_d;  skip_q <= skip_d;
         lsh_q <= lsh_d;  rsh_q <= rsh_d;  lctl_q <= lctl_d;  rctl_q <= rctl_d;
         lalt_q <= lalt_d;  ralt_q <= ralt_d;  caps_q <= caps_d;  held_q <= held_d;
         shift_q <= shift_d;  ctrl_q <= ctrl_d;  alt_q <= alt_d;
         mem_q <= mem_d;
         wr_q <= wr_d;  rd_q <= rd_d;  cnt_q <= cnt_d;
         head_q <= head_d;  valid_q <= valid_d;  ovf_q <= ovf_d;
`ifdef PS2_DEC_REPEAT_FILTER_EN
         last_vld_q <= last_vld_d;  last_q <= last_d;
`endif
      end
   end

   assign ascii       = head_q;
   assign ascii_valid = valid_q;
   assign shift_o     = shift_q;
   assign caps_o      = caps_q;
   assign ctrl_o      = ctrl_q;
   assign alt_o       = alt_q;
   assign fifo_level  = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: expected characters queued at stimulus, compared on handshake.
module tb_ps2_ascii_decoder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [7:0] ascii;
   logic       ascii_valid;
   logic       ascii_ready;
   logic       shift_o, caps_o, ctrl_o, alt_o;
   logic [3:0] fifo_level;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   logic [7:0] expq[$];
   logic [7:0] fill_codes[9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

   ps2_ascii_decoder #(.FIFO_DEPTH(8), .CTRL_MAP(1'b1), .ALT_MSB(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .ascii(ascii), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
      .shift_o(shift_o), .caps_o(caps_o), .ctrl_o(ctrl_o), .alt_o(alt_o),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted handshake must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && ascii_valid && ascii_ready) begin
         logic [8:0] e;
         if (expq.size() > 0) e = {1'b0, expq.pop_front()};
         else                 e = 9'h1FF;
         chk("ascii_out", 32'({1'b0, ascii}), 32'(e));
      end
   end

   task automatic send(input logic [7:0] b);
      byte_in = b;
      byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((expq.size() != 0 || ascii_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, 32'(expq.size()), 32'd0);
      chk({tag, "_lvl"}, 32'(fifo_level), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;  byte_in = 8'h00;  byte_valid = 1'b0;  ascii_ready = 1'b1;
      #12;
      chk("rst_ascii", 32'(ascii), 32'h0);
      chk("rst_valid", 32'(ascii_valid), 32'h0);
      chk("rst_level", 32'(fifo_level), 32'h0);
      chk("rst_mods", 32'({shift_o, caps_o, ctrl_o, alt_o, overflow}), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic make: valid the cycle after the strobe
      expq.push_back(8'h61);  send(8'h1C);
      chk("lat_valid", 32'(ascii_valid), 32'h1);
      drain("make_a");
      send(8'hF0);  send(8'h1C);  idle(2);
      chk("break_level", 32'(fifo_level), 32'h0);
      chk("break_valid", 32'(ascii_valid), 32'h0);

      // shift
      send(8'h12);
      chk("shift_on", 32'(shift_o), 32'h1);
      expq.push_back(8'h41);  send(8'h1C);
      expq.push_back(8'h40);  send(8'h1E);
      send(8'hF0);  send(8'h12);
      chk("shift_off", 32'(shift_o), 32'h0);
      expq.push_back(8'h61);  send(8'h1C);
      drain("shift_seq");

      // caps lock toggles letters only, and once per press
      send(8'h58);  send(8'hF0);  send(8'h58);
      chk("caps_on", 32'(caps_o), 32'h1);
      expq.push_back(8'h41);  send(8'h1C);
      expq.push_back(8'h31);  send(8'h16);
      send(8'h58);  send(8'h58);
      chk("caps_held", 32'(caps_o), 32'h0);
      send(8'hF0);  send(8'h58);
      drain("caps_seq");

      // ctrl, extended keys
      send(8'h14);
      chk("ctrl_on", 32'(ctrl_o), 32'h1);
      expq.push_back(8'h03);  send(8'h21);
      send(8'hF0);  send(8'h14);
      chk("ctrl_off", 32'(ctrl_o), 32'h0);
      send(8'hE0);  send(8'h14);
      chk("rctrl_on", 32'(ctrl_o), 32'h1);
      send(8'hE0);  send(8'hF0);  send(8'h14);
      chk("rctrl_off", 32'(ctrl_o), 32'h0);
      expq.push_back(8'h0D);  send(8'hE0);  send(8'h5A);
      expq.push_back(8'h2F);  send(8'hE0);  send(8'h4A);
      send(8'hE0);  send(8'h75);
      expq.push_back(8'h20);  send(8'hFA);  send(8'h29);
      drain("ext_seq");

      // fill with consumer stalled; ninth char is dropped
      ascii_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expq.push_back(8'h61 + 8'(i));
         send(fill_codes[i]);
      end
      chk("full_level", 32'(fifo_level), 32'd8);
      chk("full_no_ovf", 32'(overflow), 32'h0);
      send(fill_codes[8]);
      chk("ovf_pulse", 32'(overflow), 32'h1);
      chk("ovf_level", 32'(fifo_level), 32'd8);
      idle(1);
      chk("ovf_clear", 32'(overflow), 32'h0);
      // push and pop together while full both succeed
      ascii_ready = 1'b1;
      expq.push_back(8'h6A);  send(8'h3B);
      chk("pp_level", 32'(fifo_level), 32'd8);
      chk("pp_no_ovf", 32'(overflow), 32'h0);
      drain("fifo_seq");

      // reset in the middle of an extended prefix
      send(8'hE0);
      rst_n = 1'b0;  #3;
      chk("midrst_level", 32'(fifo_level), 32'h0);
      @(negedge clk);  rst_n = 1'b1;
      @(posedge clk); #1;
      expq.push_back(8'h61);  send(8'h1C);
      send(8'hF0);  send(8'h1C);
      drain("midrst_seq");

      // pause sequence is swallowed whole
      send(8'hE1);  send(8'h14);  send(8'h77);  send(8'hE1);
      send(8'hF0);  send(8'h14);  send(8'hF0);  send(8'h77);
      chk("pause_level", 32'(fifo_level), 32'h0);
      chk("pause_ctrl", 32'(ctrl_o), 32'h0);
      expq.push_back(8'h61);  send(8'h1C);
      send(8'hF0);  send(8'h1C);
      drain("pause_seq");

      // typematic repeat
      expq.push_back(8'h61);  send(8'h1C);
`ifndef PS2_DEC_REPEAT_FILTER_EN
      expq.push_back(8'h61);
`endif
      send(8'h1C);
`ifndef PS2_DEC_REPEAT_FILTER_EN
      expq.push_back(8'h61);
`endif
      send(8'h1C);
      send(8'hF0);  send(8'h1C);
      expq.push_back(8'h61);  send(8'h1C);
`ifndef PS2_DEC_REPEAT_FILTER_EN
      expq.push_back(8'h61);
`endif
      send(8'h1C);
      drain("repeat_seq");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
